// File: rtl/biriscv_fetch_buffer_pkg.sv
// biriscv_fetch_buffer_pkg: shared widths for the fetch-to-issue buffer.
package biriscv_fetch_buffer_pkg;
  localparam int LANE_W = 32;
  localparam int LANES_MAX = 4;
endpackage

// File: rtl/biriscv_fetch_lane_mask.sv
// biriscv_fetch_lane_mask: valid lanes of a fetch word from its start lane and predicted-taken flags.
module biriscv_fetch_lane_mask #(
  parameter int LANES = 2,
  parameter int LSW = $clog2(LANES)
) (
  input  logic [LSW-1:0]   start_i,
  input  logic [LANES-1:0] pred_i,
  output logic [LANES-1:0] mask_o
);
  logic blk;
  always_comb begin
    blk = 1'b0;
    mask_o = '0;
    for (int k = 0; k < LANES; k++) begin
      mask_o[k] = (k >= int'(start_i)) && !blk;
      blk = blk | ((k >= int'(start_i)) && pred_i[k]);
    end
  end
endmodule

// File: rtl/biriscv_fetch_buffer.sv
// biriscv_fetch_buffer: DEPTH-entry fetch word buffer with per-lane pop, start-lane masking and flush.
module biriscv_fetch_buffer
  import biriscv_fetch_buffer_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int INFO_W = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [31:0]                  pc_in_i,
  input  logic [LANES-1:0]             pred_in_i,
  input  logic [LANES*LANE_W-1:0]      data_in_i,
  input  logic [LANES*INFO_W-1:0]      info_in_i,
  output logic                         accept_o,
  output logic [LANES-1:0]             valid_o,
  output logic [LANES*32-1:0]          pc_out_o,
  output logic [LANES*LANE_W-1:0]      data_out_o,
  output logic [LANES*INFO_W-1:0]      info_out_o,
  input  logic [LANES-1:0]             pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int LSW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = 30 - LSW;
  if (!(LANES == 2 || LANES == LANES_MAX)) begin : g_bad_lanes
    $error("LANES must be 2 or 4");
  end
  logic [LANES-1:0]        valid_q [DEPTH];
  logic [LANES-1:0]        valid_d [DEPTH];
  logic [LANES*LANE_W-1:0] data_q [DEPTH];
  logic [LANES*LANE_W-1:0] data_d [DEPTH];
  logic [LANES*INFO_W-1:0] info_q [DEPTH];
  logic [LANES*INFO_W-1:0] info_d [DEPTH];
  logic [TW-1:0]           pc_q [DEPTH];
  logic [TW-1:0]           pc_d [DEPTH];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [LANES-1:0]        mask, pop_w;
  logic                    push_w, retire, unused_pc;
  biriscv_fetch_lane_mask #(.LANES(LANES)) u_mask (
    .start_i(pc_in_i[LSW+1:2]),
    .pred_i (pred_in_i),
    .mask_o (mask)
  );
  assign unused_pc = ^pc_in_i[1:0];
  assign accept_o = count_q != CW'(DEPTH);
  assign push_w = push_i & accept_o;
  assign valid_o = (count_q != '0) ? valid_q[rd_ptr_q] : '0;
  assign pop_w = pop_i & valid_o;
  assign retire = (count_q != '0) && ((valid_q[rd_ptr_q] & ~pop_w) == '0);
  assign data_out_o = data_q[rd_ptr_q];
  assign info_out_o = info_q[rd_ptr_q];
  assign count_o = count_q;
  for (genvar k = 0; k < LANES; k++) begin : g_pc
    assign pc_out_o[k*32 +: 32] = (count_q != '0) ? {pc_q[rd_ptr_q], LSW'(k), 2'b00} : '0;
  end
  always_comb begin
    valid_d = valid_q;
    data_d = data_q;
    info_d = info_q;
    pc_d = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_w && !flush_i) begin
      valid_d[wr_ptr_q] = mask;
      data_d[wr_ptr_q] = data_in_i;
      info_d[wr_ptr_q] = info_in_i;
      pc_d[wr_ptr_q] = pc_in_i[31:LSW+2];
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    // a push never lands on the head while it holds valid lanes, so pops cannot collide with it
    valid_d[rd_ptr_q] = valid_d[rd_ptr_q] & ~pop_w;
    rd_ptr_d = retire ? ((rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d = count_q + CW'(push_w) - CW'(retire);
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = '0;
        info_d[i] = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= '0;
        data_q[i] <= '0;
        info_q[i] <= '0;
        pc_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      info_q <= info_d;
      pc_q <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push_w && count_q == CW'(DEPTH))) else $error("push into full fetch buffer");
  end
endmodule

// File: tb/tb_biriscv_fetch_buffer.sv
// tb_biriscv_fetch_buffer: table vectors, queue-model random run and a 4-lane sequence.
module tb_biriscv_fetch_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_flush, a_push, a_accept;
  logic [31:0] a_pc;
  logic [1:0] a_pred, a_pop, a_valid, a_count;
  logic [63:0] a_data, a_data_out, a_pc_out;
  logic [19:0] a_info, a_info_out;

  logic b_rst, b_flush, b_push, b_accept;
  logic [31:0] b_pc;
  logic [3:0] b_pred, b_pop, b_valid;
  logic [1:0] b_count;
  logic [127:0] b_data, b_data_out, b_pc_out;
  logic [39:0] b_info, b_info_out;

  biriscv_fetch_buffer #(.LANES(2), .DEPTH(3), .INFO_W(10)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .push_i(a_push), .pc_in_i(a_pc),
    .pred_in_i(a_pred), .data_in_i(a_data), .info_in_i(a_info), .accept_o(a_accept),
    .valid_o(a_valid), .pc_out_o(a_pc_out), .data_out_o(a_data_out), .info_out_o(a_info_out),
    .pop_i(a_pop), .count_o(a_count));

  biriscv_fetch_buffer #(.LANES(4), .DEPTH(2), .INFO_W(10)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .push_i(b_push), .pc_in_i(b_pc),
    .pred_in_i(b_pred), .data_in_i(b_data), .info_in_i(b_info), .accept_o(b_accept),
    .valid_o(b_valid), .pc_out_o(b_pc_out), .data_out_o(b_data_out), .info_out_o(b_info_out),
    .pop_i(b_pop), .count_o(b_count));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: a queue of fetch words, head at index 0
  typedef struct {
    logic [1:0]  v;
    logic [63:0] d;
    logic [19:0] inf;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  function automatic logic [1:0] lane_mask(logic [31:0] pc, logic [1:0] pred);
    int s = int'((pc >> 2) % 2);
    logic [1:0] m = '0;
    for (int k = 0; k < 2; k++) begin
      m[k] = (k >= s);
      for (int j = s; j < k; j++) if (pred[j]) m[k] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] lane_pc(logic [31:0] pc, int k);
    return (pc & ~32'h7) | 32'(k * 4);
  endfunction

  task automatic model_update();
    bit acc;
    ent_t e;
    if (a_rst || a_flush) begin
      mq.delete();
    end else begin
      acc = mq.size() != 3;
      if (mq.size() > 0) begin
        e = mq[0];
        e.v = e.v & ~a_pop;
        if (e.v == 2'b00) void'(mq.pop_front());
        else mq[0] = e;
      end
      if (a_push && acc) begin
        e.v = lane_mask(a_pc, a_pred);
        e.d = a_data;
        e.inf = a_info;
        e.pc = a_pc;
        mq.push_back(e);
      end
    end
  endtask

  task automatic compare_model();
    int n = mq.size();
    chk("accept", 128'(a_accept), 128'(n != 3));
    chk("count", 128'(a_count), 128'(n));
    chk("valid", 128'(a_valid), 128'(n != 0 ? mq[0].v : 2'b00));
    if (n != 0) begin
      chk("data_out", 128'(a_data_out), 128'(mq[0].d));
      chk("info_out", 128'(a_info_out), 128'(mq[0].inf));
      chk("pc_out", 128'(a_pc_out), 128'({lane_pc(mq[0].pc, 1), lane_pc(mq[0].pc, 0)}));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  typedef struct {
    bit rst, flush, push;
    bit [1:0] pop;
    bit [31:0] pc;
    bit [1:0] pred;
    bit [1:0] ev;
    int ec;
    bit ea;
    bit [31:0] epc0;
  } vec_t;
  vec_t tbl[18];

  logic [127:0] bd0;

  initial begin
    //           rst flush push pop    pc          pred   ev     ec ea epc0
    tbl[0]  = '{1, 0, 0, 2'b00, 32'h000, 2'b00, 2'b00, 0, 1, 32'h000};
    tbl[1]  = '{0, 0, 1, 2'b00, 32'h100, 2'b00, 2'b11, 1, 1, 32'h100};
    tbl[2]  = '{0, 0, 0, 2'b10, 32'h000, 2'b00, 2'b01, 1, 1, 32'h100};
    tbl[3]  = '{0, 0, 0, 2'b01, 32'h000, 2'b00, 2'b00, 0, 1, 32'h000};
    tbl[4]  = '{0, 0, 1, 2'b00, 32'h104, 2'b00, 2'b10, 1, 1, 32'h100};
    tbl[5]  = '{0, 0, 1, 2'b01, 32'h100, 2'b01, 2'b10, 2, 1, 32'h100};
    tbl[6]  = '{0, 0, 0, 2'b11, 32'h000, 2'b00, 2'b01, 1, 1, 32'h100};
    tbl[7]  = '{0, 0, 1, 2'b11, 32'h108, 2'b00, 2'b11, 1, 1, 32'h108};
    tbl[8]  = '{0, 0, 1, 2'b00, 32'h110, 2'b00, 2'b11, 2, 1, 32'h108};
    tbl[9]  = '{0, 0, 1, 2'b00, 32'h118, 2'b00, 2'b11, 3, 0, 32'h108};
    tbl[10] = '{0, 0, 1, 2'b11, 32'h120, 2'b00, 2'b11, 2, 1, 32'h110};
    tbl[11] = '{0, 0, 1, 2'b11, 32'h128, 2'b00, 2'b11, 2, 1, 32'h118};
    tbl[12] = '{0, 0, 1, 2'b00, 32'h130, 2'b00, 2'b11, 3, 0, 32'h118};
    tbl[13] = '{0, 1, 1, 2'b11, 32'h140, 2'b00, 2'b00, 0, 1, 32'h000};
    tbl[14] = '{0, 0, 1, 2'b00, 32'h150, 2'b00, 2'b11, 1, 1, 32'h150};
    tbl[15] = '{0, 0, 1, 2'b00, 32'h158, 2'b00, 2'b11, 2, 1, 32'h150};
    tbl[16] = '{1, 0, 0, 2'b11, 32'h000, 2'b00, 2'b00, 0, 1, 32'h000};
    tbl[17] = '{0, 0, 0, 2'b11, 32'h000, 2'b00, 2'b00, 0, 1, 32'h000};

    {a_rst, a_flush, a_push, a_pc, a_pred, a_pop, a_data, a_info} = '0;
    {b_flush, b_push, b_pc, b_pred, b_pop, b_data, b_info} = '0;
    b_rst = 1'b1;
    #2;
    for (int i = 0; i < 18; i++) begin
      a_rst = tbl[i].rst;
      a_flush = tbl[i].flush;
      a_push = tbl[i].push;
      a_pop = tbl[i].pop;
      a_pc = tbl[i].pc;
      a_pred = tbl[i].pred;
      a_data = {$urandom, $urandom};
      a_info = 20'($urandom);
      step();
      chk($sformatf("row%0d valid", i), 128'(a_valid), 128'(tbl[i].ev));
      chk($sformatf("row%0d count", i), 128'(a_count), 128'(tbl[i].ec));
      chk($sformatf("row%0d accept", i), 128'(a_accept), 128'(tbl[i].ea));
      if (tbl[i].ec != 0) chk($sformatf("row%0d pc0", i), 128'(a_pc_out[31:0]), 128'(tbl[i].epc0));
      if (tbl[i].rst) begin
        chk($sformatf("row%0d rst data", i), 128'(a_data_out), 128'(0));
        chk($sformatf("row%0d rst info", i), 128'(a_info_out), 128'(0));
        chk($sformatf("row%0d rst pc", i), 128'(a_pc_out), 128'(0));
      end
      b_rst = 1'b0;
    end

    {a_rst, a_flush, a_push, a_pop} = '0;
    b_push = 1'b1;
    b_pc = 32'h108;
    b_pred = 4'b0100;
    b_data = {$urandom, $urandom, $urandom, $urandom};
    bd0 = b_data;
    b_info = 40'h12_3456_789A;
    step();
    chk("b4 valid start2", 128'(b_valid), 128'(4'b0100));
    chk("b4 count1", 128'(b_count), 128'(1));
    chk("b4 pc lane2", 128'(b_pc_out[95:64]), 128'(32'h108));
    chk("b4 pc lane3", 128'(b_pc_out[127:96]), 128'(32'h10C));
    chk("b4 data", b_data_out, bd0);
    b_pc = 32'h100;
    b_pred = 4'b0000;
    b_data = {$urandom, $urandom, $urandom, $urandom};
    bd0 = b_data;
    step();
    chk("b4 count full", 128'(b_count), 128'(2));
    chk("b4 accept full", 128'(b_accept), 128'(0));
    b_pc = 32'h200;
    b_pop = 4'b1110;
    step();
    chk("b4 count retire", 128'(b_count), 128'(1));
    chk("b4 valid next", 128'(b_valid), 128'(4'b1111));
    chk("b4 data next", b_data_out, bd0);
    chk("b4 pc lane0", 128'(b_pc_out[31:0]), 128'(32'h100));
    b_push = 1'b0;
    b_pop = 4'b1111;
    step();
    chk("b4 drained", 128'(b_count), 128'(0));
    chk("b4 drained valid", 128'(b_valid), 128'(0));
    b_pop = 4'b0000;

    for (int i = 0; i < 3000; i++) begin
      a_rst = ($urandom_range(99) == 0);
      a_flush = ($urandom_range(49) == 0);
      a_push = ($urandom_range(9) < 7);
      a_pop = 2'($urandom);
      a_pc = $urandom & 32'hFFFF_FFFC;
      a_pred = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      a_data = {$urandom, $urandom};
      a_info = 20'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
